// File: rtl/ma_cvxif_dispatch.sv
// ma_cvxif_dispatch: CVXIF custom-0 front-end feeding an in-order command FIFO to the matrix accelerator.
// Optional performance counters are built only when MA_CVXIF_PERF_EN is defined.
module ma_cvxif_dispatch #(
  parameter int IdWidth  = 3,
  parameter int CmdDepth = 4,
  parameter int XLen     = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLen-1:0]    issue_rs1_i,
  input  logic [XLen-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [9:0]         cmd_op_o,
  output logic [XLen-1:0]    cmd_rs1_o,
  output logic [XLen-1:0]    cmd_rs2_o,
  output logic [IdWidth-1:0] cmd_id_o,
  output logic               cmd_wb_o,
  input  logic               rsp_valid_i,
  output logic               rsp_ready_o,
  input  logic [IdWidth-1:0] rsp_id_i,
  input  logic [XLen-1:0]    rsp_data_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLen-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic [31:0]        perf_accepted_o,
  output logic [31:0]        perf_killed_o
);

  localparam int NumSlots = 2**IdWidth;
  localparam int PtrW     = $clog2(CmdDepth);

  typedef struct packed {
    logic [9:0]      op;
    logic [XLen-1:0] rs1;
    logic [XLen-1:0] rs2;
    logic            wb;
  } slot_t;

  typedef struct packed {
    logic [9:0]         op;
    logic [XLen-1:0]    rs1;
    logic [XLen-1:0]    rs2;
    logic [IdWidth-1:0] id;
    logic               wb;
  } cmd_t;

  logic                active_q, active_d;
  logic [NumSlots-1:0] slot_valid_q, slot_valid_d;
  slot_t               slot_q [NumSlots];
  slot_t               slot_d [NumSlots];
  logic [4:0]          rd_q [NumSlots];
  logic [4:0]          rd_d [NumSlots];
  logic [NumSlots-1:0] wb_tbl_q, wb_tbl_d;
  logic [IdWidth:0]    pend_cnt_q, pend_cnt_d;

  cmd_t                fifo_q [CmdDepth];
  cmd_t                fifo_d [CmdDepth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       fifo_cnt_q, fifo_cnt_d;

  logic                result_valid_q, result_valid_d;
  logic [IdWidth-1:0]  result_id_q, result_id_d;
  logic [XLen-1:0]     result_data_q, result_data_d;
  logic [4:0]          result_rd_q, result_rd_d;

  logic dec_match_s, dec_wb_s, issue_alloc_s;
  logic commit_hit_s, push_s, kill_s, pop_s, rsp_fire_s;
  cmd_t head_s;

  assign dec_match_s = (issue_instr_i[6:0] == 7'b0001011);
  assign dec_wb_s    = dec_match_s && issue_instr_i[14] && (issue_instr_i[11:7] != 5'd0);

  // active_q keeps ready low while in reset and for the first cycle after release
  assign issue_ready_o = active_q && !slot_valid_q[issue_id_i] &&
                         ((32'(fifo_cnt_q) + 32'(pend_cnt_q)) < 32'(CmdDepth));

  assign issue_alloc_s     = issue_valid_i && issue_ready_o && dec_match_s;
  assign issue_accept_o    = issue_alloc_s;
  assign issue_writeback_o = issue_alloc_s && dec_wb_s;

  assign commit_hit_s = commit_valid_i && slot_valid_q[commit_id_i];
  assign push_s       = commit_hit_s && !commit_kill_i;
  assign kill_s       = commit_hit_s && commit_kill_i;

  assign head_s      = fifo_q[rd_ptr_q];
  assign cmd_valid_o = (fifo_cnt_q != '0);
  assign pop_s       = cmd_valid_o && cmd_ready_i;
  assign cmd_op_o    = cmd_valid_o ? head_s.op  : 10'd0;
  assign cmd_rs1_o   = cmd_valid_o ? head_s.rs1 : '0;
  assign cmd_rs2_o   = cmd_valid_o ? head_s.rs2 : '0;
  assign cmd_id_o    = cmd_valid_o ? head_s.id  : '0;
  assign cmd_wb_o    = cmd_valid_o && head_s.wb;

  assign rsp_ready_o = !result_valid_q || result_ready_i;
  assign rsp_fire_s  = rsp_valid_i && rsp_ready_o;

  assign result_valid_o = result_valid_q;
  assign result_id_o    = result_id_q;
  assign result_data_o  = result_data_q;
  assign result_rd_o    = result_rd_q;
  assign result_we_o    = result_valid_q;

  // Next state for pending table, command FIFO and result register
  always_comb begin
    active_d       = 1'b1;
    slot_valid_d   = slot_valid_q;
    slot_d         = slot_q;
    rd_d           = rd_q;
    wb_tbl_d       = wb_tbl_q;
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    result_valid_d = result_valid_q;
    result_id_d    = result_id_q;
    result_data_d  = result_data_q;
    result_rd_d    = result_rd_q;

    if (issue_alloc_s) begin
      slot_valid_d[issue_id_i] = 1'b1;
      slot_d[issue_id_i].op    = {issue_instr_i[31:25], issue_instr_i[14:12]};
      slot_d[issue_id_i].rs1   = issue_rs1_i;
      slot_d[issue_id_i].rs2   = issue_rs2_i;
      slot_d[issue_id_i].wb    = dec_wb_s;
      rd_d[issue_id_i]         = issue_instr_i[11:7];
      wb_tbl_d[issue_id_i]     = dec_wb_s;
    end

    // Ready reservation guarantees the issue and commit IDs differ
    if (commit_hit_s) begin
      slot_valid_d[commit_id_i] = 1'b0;
    end

    if (push_s) begin
      fifo_d[wr_ptr_q].op  = slot_q[commit_id_i].op;
      fifo_d[wr_ptr_q].rs1 = slot_q[commit_id_i].rs1;
      fifo_d[wr_ptr_q].rs2 = slot_q[commit_id_i].rs2;
      fifo_d[wr_ptr_q].id  = commit_id_i;
      fifo_d[wr_ptr_q].wb  = slot_q[commit_id_i].wb;
      wr_ptr_d             = wr_ptr_q + PtrW'(1);
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    if (rsp_fire_s && wb_tbl_q[rsp_id_i]) begin
      result_valid_d = 1'b1;
      result_id_d    = rsp_id_i;
      result_data_d  = rsp_data_i;
      result_rd_d    = rd_q[rsp_id_i];
    end else if (result_valid_q && result_ready_i) begin
      result_valid_d = 1'b0;
    end

    fifo_cnt_d = fifo_cnt_q + (PtrW+1)'(push_s) - (PtrW+1)'(pop_s);
    pend_cnt_d = pend_cnt_q + (IdWidth+1)'(issue_alloc_s) - (IdWidth+1)'(commit_hit_s);
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q       <= 1'b0;
      slot_valid_q   <= '0;
      wb_tbl_q       <= '0;
      pend_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_data_q  <= '0;
      result_rd_q    <= 5'd0;
      for (int i = 0; i < NumSlots; i++) begin
        slot_q[i] <= '0;
        rd_q[i]   <= 5'd0;
      end
      for (int i = 0; i < CmdDepth; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      active_q       <= active_d;
      slot_valid_q   <= slot_valid_d;
      slot_q         <= slot_d;
      rd_q           <= rd_d;
      wb_tbl_q       <= wb_tbl_d;
      pend_cnt_q     <= pend_cnt_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_data_q  <= result_data_d;
      result_rd_q    <= result_rd_d;
    end
  end

`ifdef MA_CVXIF_PERF_EN
  logic [31:0] perf_acc_q, perf_acc_d, perf_kill_q, perf_kill_d;

  // Wrapping event counters
  always_comb begin
    perf_acc_d  = perf_acc_q + 32'(issue_alloc_s);
    perf_kill_d = perf_kill_q + 32'(kill_s);
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_acc_q  <= 32'd0;
      perf_kill_q <= 32'd0;
    end else begin
      perf_acc_q  <= perf_acc_d;
      perf_kill_q <= perf_kill_d;
    end
  end

  assign perf_accepted_o = perf_acc_q;
  assign perf_killed_o   = perf_kill_q;
  logic unused_s;
  assign unused_s = ^issue_instr_i[24:15];
`else
  assign perf_accepted_o = 32'd0;
  assign perf_killed_o   = 32'd0;
  logic unused_s;
  assign unused_s = ^{issue_instr_i[24:15], kill_s};
`endif

endmodule
